// File: rtl/switch_mode_reader.sv
// DIP-switch front end: 2-flop sync, per-bit debounce, one-hot mode classification.
// Optional STICKY_FAULT_EN: FAULT latches until all switches read off.
module switch_mode_reader #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DEBOUNCE_MAX = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] mode,
  output logic             mode_valid,
  output logic             mode_change,
  output logic             fault
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_MAX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_MAX - 1);

  typedef enum logic [1:0] {StIdle, StActive, StFault} state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mode_q, mode_d;
  logic             change_q, change_d;
  logic             clean_zero, clean_one_hot;

  // Synchroniser and debounce state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Counter clears whenever the synced level matches or the new level is accepted,
  // so it never exceeds DEBOUNCE_MAX-1.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign clean_zero    = (clean_q == '0);
  assign clean_one_hot = !clean_zero && ((clean_q & (clean_q - WIDTH'(1))) == '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      change_q <= change_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clean_zero) begin
      state_d = StIdle;
    end else if (clean_one_hot) begin
`ifdef STICKY_FAULT_EN
      state_d = (state_q == StFault) ? StFault : StActive;
`else
      state_d = StActive;
`endif
    end else begin
      state_d = StFault;
    end
  end

  // FSM outputs, computed from the next state so they register alongside it
  always_comb begin
    mode_d   = '0;
    change_d = 1'b0;
    if (state_d == StActive) begin
      mode_d = clean_q;
    end
    change_d = (mode_d != mode_q);
  end

  assign sw_clean    = clean_q;
  assign mode        = mode_q;
  assign mode_valid  = (state_q == StActive);
  assign fault       = (state_q == StFault);
  assign mode_change = change_q;

endmodule

// File: tb/tb_switch_mode_reader.sv
// Scoreboard bench for switch_mode_reader with DEBOUNCE_MAX=8.
// Expected outputs are queued on each switch change and checked on the MODE_CHANGE pulse.
module tb_switch_mode_reader;

  localparam int unsigned W  = 4;
  localparam int unsigned DB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean, mode;
  logic         mode_valid, mode_change, fault;

  int n_checks = 0;
  int n_errors = 0;
  int chg_cnt  = 0;
  int fault_cnt = 0;

  typedef struct {
    logic [W-1:0] mode;
    logic         valid;
    logic         fault;
    logic [W-1:0] clean;
    int           lat;
  } exp_t;

  exp_t sb[$];

  switch_mode_reader #(
    .WIDTH       (W),
    .DEBOUNCE_MAX(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_change(mode_change),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mode_change) chg_cnt++;
    if (fault) fault_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a new switch word just after a rising edge and queue what must follow.
  task automatic drive_expect(input logic [W-1:0] raw, input logic [W-1:0] m, input logic v,
                              input logic f, input logic [W-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    sw_raw = raw;
    e.mode = m; e.valid = v; e.fault = f; e.clean = c; e.lat = int'(DB) + 3;
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   cyc;
    int   clean_cyc;
    int   base;
    e = sb.pop_front();
    base = chg_cnt;
    clean_cyc = -1;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (clean_cyc < 0 && sw_clean == e.clean) clean_cyc = cyc;
      if (mode_change) break;
    end
    check({tag, " change_lat"}, cyc, e.lat);
    check({tag, " clean_lat"}, clean_cyc, e.lat - 1);
    check({tag, " mode"}, mode, e.mode);
    check({tag, " valid"}, mode_valid, e.valid);
    check({tag, " fault"}, fault, e.fault);
    check({tag, " sw_clean"}, sw_clean, e.clean);
    repeat (4) @(negedge clk);
    check({tag, " pulses"}, chg_cnt - base, 1);
  endtask

  initial begin
    int   base;
    logic moved;
    rst_n  = 1'b0;
    sw_raw = '0;

    // 1: outputs held at zero under reset regardless of switch activity
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      sw_raw = W'($urandom_range(15, 1));
      @(negedge clk);
      check("reset outputs", {sw_clean, mode, mode_valid, mode_change, fault}, '0);
    end
    @(posedge clk);
    #1;
    sw_raw = '0;
    rst_n  = 1'b1;
    repeat (30) @(negedge clk);
    check("idle after release", {sw_clean, mode, mode_valid, mode_change, fault}, '0);
    check("idle no pulses", chg_cnt, 0);

    // 2: single switch on
    drive_expect(4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010);
    collect("mode2");

    // 3: back to idle, then bounce bit0 before settling high
    drive_expect(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
    collect("idle");
    base  = chg_cnt;
    moved = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      sw_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (3) begin
        @(negedge clk);
        if (sw_clean != '0) moved = 1'b1;
      end
    end
    check("bounce clean steady", moved, 1'b0);
    check("bounce no pulses", chg_cnt - base, 0);
    drive_expect(4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001);
    collect("bounce settle");

    // 4: direct 1->2, then two switches on gives fault
    drive_expect(4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010);
    collect("mode1to2");
    drive_expect(4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0110);
    collect("fault");
`ifdef STICKY_FAULT_EN
    base = chg_cnt;
    @(posedge clk);
    #1;
    sw_raw = 4'b0100;
    repeat (15) @(negedge clk);
    check("sticky fault", fault, 1'b1);
    check("sticky mode", mode, 4'b0000);
    check("sticky valid", mode_valid, 1'b0);
    check("sticky clean", sw_clean, 4'b0100);
    @(posedge clk);
    #1;
    sw_raw = 4'b0000;
    repeat (15) @(negedge clk);
    check("sticky exit fault", fault, 1'b0);
    check("sticky exit mode", mode, 4'b0000);
    check("sticky no pulses", chg_cnt - base, 0);
    drive_expect(4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0100);
    collect("mode4");
`else
    drive_expect(4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0100);
    collect("fault exit mode4");
`endif

    // 5: two bits swap on the same cycle; no transient fault
    base = fault_cnt;
    drive_expect(4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000);
    collect("mode4to8");
    check("swap no fault", fault_cnt - base, 0);

    // 6: reset partway through a pending change
    @(posedge clk);
    #1;
    sw_raw = 4'b0001;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset outputs", {sw_clean, mode, mode_valid, mode_change, fault}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      exp_t e;
      e.mode = 4'b0001; e.valid = 1'b1; e.fault = 1'b0; e.clean = 4'b0001; e.lat = int'(DB) + 3;
      sb.push_back(e);
    end
    collect("post reset");

    check("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
